// File: rtl/haraka_sponge_ctrl.sv
// Sequencing controller for the Haraka-S sponge: absorbs padded rate blocks,
// steps the round-iterative permutation, and squeezes the requested digest.
module haraka_sponge_ctrl #(
  parameter int ROUNDS    = 5,
  parameter int RATE_BITS = 256,
  parameter int LEN_W     = 64
) (
  input  logic                         internal_clk,
  input  logic                         reset,
  input  logic                         blk_valid,
  input  logic                         blk_last,
  output logic                         blk_ready,
  input  logic [LEN_W-1:0]             digest_length,
  output logic                         perm_start,
  output logic                         sel_xor,
  output logic [$clog2(ROUNDS)-1:0]    perm_round,
  output logic                         state_we,
  output logic                         state_clr,
  output logic                         sq_valid,
  input  logic                         sq_ready,
  output logic                         sq_last,
  output logic [$clog2(RATE_BITS):0]   sq_bits,
  output logic                         busy
);

  localparam int LOG2R = $clog2(RATE_BITS);
  localparam int RW    = $clog2(ROUNDS);
  localparam int SQW   = LOG2R + 1;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    PERM,
    CAPTURE,
    SQUEEZE
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [LOG2R-1:0]   tail_q, tail_d;
  logic               last_q, last_d;
  logic [RW-1:0]      round_q, round_d;
  logic               final_blk;

  assign final_blk = (remaining_q == LEN_W'(1));

  always_ff @(posedge internal_clk or posedge reset) begin
    if (reset) begin
      state_q     <= CLEAR;
      remaining_q <= '0;
      tail_q      <= '0;
      last_q      <= 1'b0;
      round_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      tail_q      <= tail_d;
      last_q      <= last_d;
      round_q     <= round_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tail_d      = tail_q;
    last_d      = last_q;
    round_d     = round_q;
    blk_ready   = 1'b0;
    perm_start  = 1'b0;
    sel_xor     = 1'b0;
    perm_round  = '0;
    state_we    = 1'b0;
    state_clr   = 1'b0;
    sq_valid    = 1'b0;
    sq_last     = 1'b0;
    sq_bits     = '0;
    busy        = (state_q != IDLE);

    unique case (state_q)
      CLEAR: begin
        state_clr = 1'b1;
        state_d   = IDLE;
      end
      IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          perm_start = 1'b1;
          sel_xor    = 1'b1;
          last_d     = blk_last;
          if (blk_last) begin
            // Block count is ceil(L / RATE_BITS); fits in LEN_W since L >> LOG2R leaves headroom.
            remaining_d = (digest_length >> LOG2R)
                        + LEN_W'(digest_length[LOG2R-1:0] != '0);
            tail_d      = digest_length[LOG2R-1:0];
          end
          state_d = PERM;
        end
      end
      PERM: begin
        perm_round = round_q;
        if (round_q == RW'(ROUNDS - 1)) begin
          round_d = '0;
          state_d = CAPTURE;
        end else begin
          round_d = round_q + RW'(1);
        end
      end
      CAPTURE: begin
        state_we = 1'b1;
        if (!last_q)
          state_d = IDLE;
        else if (remaining_q == '0)
          state_d = CLEAR;
        else
          state_d = SQUEEZE;
      end
      SQUEEZE: begin
        sq_valid = 1'b1;
        sq_last  = final_blk;
        sq_bits  = (final_blk && tail_q != '0) ? SQW'(tail_q) : SQW'(RATE_BITS);
        if (sq_ready) begin
          if (final_blk) begin
            state_d = CLEAR;
          end else begin
            remaining_d = remaining_q - LEN_W'(1);
            perm_start  = 1'b1;
            state_d     = PERM;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

endmodule
